// File: rtl/simd_rotate_pipe.sv
// EX-stage issue/retire wrapper around the combinational SIMD rotator.
// One operand register (S1) feeds the rotator; results queue with their tags in a small FIFO.
module simd_rotate_pipe #(
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [0:63]                     in_op1,
  input  logic [1:0]                      in_ww,
  input  logic [TAG_W-1:0]                in_tag,
  output logic [0:63]                     rot_op1,
  output logic [1:0]                      rot_ww,
  input  logic [0:63]                     rot_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [0:63]                     out_data,
  output logic [TAG_W-1:0]                out_tag,
  output logic [$clog2(FIFO_DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [0:63]      mem_data [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag  [FIFO_DEPTH];

  logic full;
  logic push;
  logic pop;
  logic accept;

  // Full/empty come from the occupancy count so pointers can wrap freely.
  assign full      = (occupancy == OCC_W'(FIFO_DEPTH));
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid & out_ready;
  assign push      = s1_valid & (~full | pop);
  assign in_ready  = ~flush & (~s1_valid | push);
  assign accept    = in_valid & in_ready;
  assign out_data  = mem_data[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];

  // S1 drives the rotator directly; operand and tag only change on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      rot_op1  <= '0;
      rot_ww   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_tag   <= in_tag;
      rot_op1  <= in_op1;
      rot_ww   <= in_ww;
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

  // Result FIFO; storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= rot_result;
        mem_tag[wr_ptr]  <= s1_tag;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
    end
  end

endmodule

// File: tb/tb_simd_rotate_pipe.sv
// Directed bench for simd_rotate_pipe: a table of single-op vectors plus hand-written
// sequences for back-to-back issue, backpressure, full+pop, flush and async reset.
module tb_simd_rotate_pipe;

  localparam int TAG_W = 5;

  typedef struct {
    logic [63:0]      op1;
    logic [1:0]       ww;
    logic [TAG_W-1:0] tag;
    logic [63:0]      exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [0:63]      in_op1;
  logic [1:0]       in_ww;
  logic [TAG_W-1:0] in_tag;
  logic [0:63]      rot_op1;
  logic [1:0]       rot_ww;
  logic [0:63]      rot_result;
  logic             out_valid;
  logic             out_ready;
  logic [0:63]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       occupancy;

  int checks = 0;
  int passes = 0;

  localparam logic [63:0] A  = 64'h0123456789ABCDEF;
  localparam logic [63:0] R0 = 64'h1032547698BADCFE;
  localparam logic [63:0] R1 = 64'h23016745AB89EFCD;
  localparam logic [63:0] R2 = 64'h45670123CDEF89AB;
  localparam logic [63:0] R3 = 64'h89ABCDEF01234567;

  simd_rotate_pipe #(.FIFO_DEPTH(2), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op1(in_op1), .in_ww(in_ww), .in_tag(in_tag),
    .rot_op1(rot_op1), .rot_ww(rot_ww), .rot_result(rot_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external rotator: each element is rotated by half its width.
  function automatic logic [63:0] rotModel(input logic [63:0] v, input logic [1:0] ww);
    case (ww)
      2'b00:   return ((v & 64'h0F0F0F0F0F0F0F0F) << 4)  | ((v >> 4)  & 64'h0F0F0F0F0F0F0F0F);
      2'b01:   return ((v & 64'h00FF00FF00FF00FF) << 8)  | ((v >> 8)  & 64'h00FF00FF00FF00FF);
      2'b10:   return ((v & 64'h0000FFFF0000FFFF) << 16) | ((v >> 16) & 64'h0000FFFF0000FFFF);
      default: return {v[31:0], v[63:32]};
    endcase
  endfunction

  always_comb rot_result = rotModel(rot_op1, rot_ww);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] op, input logic [1:0] ww,
                               input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_op1   = op;
    in_ww    = ww;
    in_tag   = tag;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Three accepted ops with out_ready low leave the FIFO full and S1 loaded.
  task automatic fillUp(input logic [TAG_W-1:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, A, 2'(i), base + TAG_W'(i));
      #1 checkOutput("fill_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    applyStimulus(1'b0, A, 2'b00, '0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{A, 2'b00, 5'd1, R0};
    vecs[1] = '{A, 2'b01, 5'd2, R1};
    vecs[2] = '{A, 2'b10, 5'd3, R2};
    vecs[3] = '{A, 2'b11, 5'd4, R3};
    vecs[4] = '{64'hFEDCBA9876543210, 2'b00, 5'd5,  64'hEFCDAB8967452301};
    vecs[5] = '{64'hFEDCBA9876543210, 2'b01, 5'd6,  64'hDCFE98BA54761032};
    vecs[6] = '{64'hFEDCBA9876543210, 2'b10, 5'd7,  64'hBA98FEDC32107654};
    vecs[7] = '{64'h8000000000000001, 2'b11, 5'd31, 64'h0000000180000000};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    applyStimulus(1'b0, '0, 2'b00, '0);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_rot_op1", rot_op1, 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single-op latency: accept at edge k, result visible after edge k+1, popped at k+2.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].op1, vecs[i].ww, vecs[i].tag);
      #1 checkOutput("vec_in_ready", 64'(in_ready), 64'd1);
      step();
      applyStimulus(1'b0, '0, 2'b00, '0);
      #1;
      checkOutput("vec_rot_op1", rot_op1, vecs[i].op1);
      checkOutput("vec_rot_ww", 64'(rot_ww), 64'(vecs[i].ww));
      checkOutput("vec_early_valid", 64'(out_valid), 64'd0);
      step();
      checkOutput("vec_out_valid", 64'(out_valid), 64'd1);
      checkOutput("vec_out_data", out_data, vecs[i].exp);
      checkOutput("vec_out_tag", 64'(out_tag), 64'(vecs[i].tag));
      step();
      checkOutput("vec_drained", 64'(out_valid), 64'd0);
    end

    // Back-to-back issue, one result per cycle in order.
    applyStimulus(1'b1, A, 2'b01, 5'd1); step();
    applyStimulus(1'b1, A, 2'b10, 5'd2);
    #1 checkOutput("b2b_ready", 64'(in_ready), 64'd1);
    step();
    checkOutput("b2b_data1", out_data, R1);
    checkOutput("b2b_tag1", 64'(out_tag), 64'd1);
    applyStimulus(1'b1, A, 2'b11, 5'd3);
    #1 checkOutput("b2b_ready2", 64'(in_ready), 64'd1);
    step();
    checkOutput("b2b_data2", out_data, R2);
    checkOutput("b2b_tag2", 64'(out_tag), 64'd2);
    applyStimulus(1'b0, '0, 2'b00, '0);
    step();
    checkOutput("b2b_data3", out_data, R3);
    checkOutput("b2b_tag3", 64'(out_tag), 64'd3);
    step();
    checkOutput("b2b_empty", 64'(out_valid), 64'd0);

    // Backpressure: fourth op refused while FIFO full and S1 holds.
    fillUp(5'd10);
    applyStimulus(1'b1, A, 2'b11, 5'd13);
    #1;
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_occupancy", 64'(occupancy), 64'd2);
    checkOutput("bp_head_tag", 64'(out_tag), 64'd10);
    checkOutput("bp_head_data", out_data, R0);
    step();
    checkOutput("bp_hold_ww", 64'(rot_ww), 64'd2);
    checkOutput("bp_hold_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_hold_tag", 64'(out_tag), 64'd10);
    applyStimulus(1'b0, '0, 2'b00, '0);
    out_ready = 1'b1;
    step();
    checkOutput("bp_drain_tag1", 64'(out_tag), 64'd11);
    checkOutput("bp_drain_data1", out_data, R1);
    checkOutput("bp_drain_occ1", 64'(occupancy), 64'd2);
    step();
    checkOutput("bp_drain_tag2", 64'(out_tag), 64'd12);
    checkOutput("bp_drain_data2", out_data, R2);
    checkOutput("bp_drain_occ2", 64'(occupancy), 64'd1);
    step();
    checkOutput("bp_drain_empty", 64'(out_valid), 64'd0);

    // Full FIFO with simultaneous pop, push and accept.
    fillUp(5'd20);
    out_ready = 1'b1;
    applyStimulus(1'b1, A, 2'b11, 5'd23);
    #1 checkOutput("fp_in_ready", 64'(in_ready), 64'd1);
    step();
    applyStimulus(1'b0, '0, 2'b00, '0);
    checkOutput("fp_occupancy", 64'(occupancy), 64'd2);
    checkOutput("fp_tag", 64'(out_tag), 64'd21);
    checkOutput("fp_rot_ww", 64'(rot_ww), 64'd3);
    step();
    checkOutput("fp_tag2", 64'(out_tag), 64'd22);
    checkOutput("fp_occ2", 64'(occupancy), 64'd2);
    step();
    checkOutput("fp_tag3", 64'(out_tag), 64'd23);
    checkOutput("fp_data3", out_data, R3);
    step();
    checkOutput("fp_empty", 64'(out_valid), 64'd0);

    // Flush with S1 and FIFO full: everything dropped, new op still works.
    fillUp(5'd30);
    flush = 1'b1;
    applyStimulus(1'b1, A, 2'b11, 5'd33);
    #1 checkOutput("fl_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, 2'b00, '0);
    #1;
    checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_occupancy", 64'(occupancy), 64'd0);
    checkOutput("fl_in_ready_after", 64'(in_ready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("fl_no_ghost", 64'(out_valid), 64'd0);
    end
    applyStimulus(1'b1, A, 2'b01, 5'd7); step();
    applyStimulus(1'b0, '0, 2'b00, '0); step();
    checkOutput("fl_post_tag", 64'(out_tag), 64'd7);
    checkOutput("fl_post_data", out_data, R1);

    // Asynchronous reset between edges with work in flight.
    step();
    applyStimulus(1'b1, A, 2'b00, 5'd4); step();
    applyStimulus(1'b1, A, 2'b01, 5'd5); step();
    checkOutput("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("ar_out_valid", 64'(out_valid), 64'd0);
    checkOutput("ar_occupancy", 64'(occupancy), 64'd0);
    checkOutput("ar_rot_op1", rot_op1, 64'd0);
    checkOutput("ar_rot_ww", 64'(rot_ww), 64'd0);
    checkOutput("ar_out_data", out_data, 64'd0);
    checkOutput("ar_out_tag", 64'(out_tag), 64'd0);
    applyStimulus(1'b0, '0, 2'b00, '0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 64'h8000000000000001, 2'b11, 5'd9); step();
    applyStimulus(1'b0, '0, 2'b00, '0); step();
    checkOutput("ar_post_valid", 64'(out_valid), 64'd1);
    checkOutput("ar_post_data", out_data, 64'h0000000180000000);
    checkOutput("ar_post_tag", 64'(out_tag), 64'd9);
    step();
    checkOutput("ar_post_empty", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
